// File: rtl/ad7276_axis_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ad7276_pkg
//  Purpose  : Shared widths and the sample-pair packing function for the
//             AD7276 AXI4-Stream packer.
//  Revision : 1.0
// ============================================================================
package ad7276_pkg;

    localparam int ADC_DATA_W  = 12;
    localparam int AXIS_DATA_W = 32;
    localparam int PAD_W       = 4;

    typedef logic [ADC_DATA_W-1:0]  adc_sample_t;
    typedef logic [AXIS_DATA_W-1:0] axis_word_t;

    // A disabled channel is sent as zero so the word layout never shifts.
    function automatic axis_word_t pack_word(input adc_sample_t ch0,
                                             input adc_sample_t ch1,
                                             input logic        en0,
                                             input logic        en1);
        adc_sample_t f0;
        adc_sample_t f1;
        f0 = en0 ? ch0 : '0;
        f1 = en1 ? ch1 : '0;
        return {{PAD_W{1'b0}}, f1, {PAD_W{1'b0}}, f0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ad7276_axis_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : ad7276_axis_packer_if
//  Purpose  : AXI4-Stream bus carrying packed AD7276 sample pairs.
//  Revision : 1.0
// ============================================================================
interface ad7276_axis_packer_if;
    import ad7276_pkg::*;

    axis_word_t tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/ad7276_axis_packer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : axis_sample_fifo
//  Purpose  : Synchronous first-word-fall-through FIFO; head entry is always
//             visible on rdata while not empty.
//  Revision : 1.0
// ============================================================================
module axis_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         wdata,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         rdata,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   level
);

    localparam int            c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_level == c_FULL);
    assign empty  = (r_level == '0);
    assign level  = r_level;
    assign rdata  = r_mem[r_rd_ptr];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ad7276_axis_packer.sv
`default_nettype none
// ============================================================================
//  Module   : ad7276_axis_packer
//  Purpose  : Captures AD7276 sample pairs on data-ready rising edges, packs
//             them into 32-bit words and streams them out with TLAST framing.
//  Revision : 1.0
// ============================================================================
module ad7276_axis_packer
    import ad7276_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int PACKET_LEN = 256,
    parameter int CNT_W      = 16
) (
    input  wire logic                          fpga_clk_i,
    input  wire logic                          reset_n_i,
    input  wire logic                          enable_i,
    input  wire logic                          en_0_i,
    input  wire logic                          en_1_i,
    input  wire logic                          data_rdy_i,
    input  wire logic [ADC_DATA_W-1:0]         data_0_i,
    input  wire logic [ADC_DATA_W-1:0]         data_1_i,
    input  wire logic                          clr_ovf_i,
    ad7276_axis_packer_if.master               m_axis,
    output logic      [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                               overflow_o,
    output logic      [CNT_W-1:0]              drop_cnt_o
);

    localparam logic [15:0] c_LAST_BEAT = 16'(PACKET_LEN - 1);

    logic             r_rdy_q;
    logic [15:0]      r_beat_cnt;
    logic             r_overflow;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_push_req;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_drop;
    logic             w_pop;
    axis_word_t       w_push_word;

    assign w_push_req  = data_rdy_i & ~r_rdy_q & enable_i;
    assign w_push_word = pack_word(data_0_i, data_1_i, en_0_i, en_1_i);
    // Fullness is judged before this cycle's pop, so a full FIFO drops even
    // when a beat leaves in the same cycle.
    assign w_drop      = w_push_req & w_fifo_full;
    assign w_pop       = m_axis.tvalid & m_axis.tready;

    assign m_axis.tvalid = ~w_fifo_empty;
    assign m_axis.tlast  = m_axis.tvalid & (r_beat_cnt == c_LAST_BEAT);
    assign overflow_o    = r_overflow;
    assign drop_cnt_o    = r_drop_cnt;

    axis_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (AXIS_DATA_W)
    ) u_fifo (
        .clk   (fpga_clk_i),
        .rst_n (reset_n_i),
        .push  (w_push_req),
        .wdata (w_push_word),
        .pop   (w_pop),
        .rdata (m_axis.tdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (fifo_level_o)
    );

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rdy_q    <= 1'b0;
            r_beat_cnt <= '0;
        end else begin
            r_rdy_q <= data_rdy_i;
            if (w_pop) begin
                r_beat_cnt <= m_axis.tlast ? '0 : r_beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_ovf_i)            r_drop_cnt <= CNT_W'(1);
            else if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
        end else if (clr_ovf_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

endmodule
`default_nettype wire
